// File: rtl/gate_bist_pkg.sv
// Shared types and truth-table constants for the gate BIST sequencer.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } bist_state_t;

    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/bist_settle_cnt.sv
// Loadable down-counter with zero flag; times the settle interval of each vector.
module bist_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Exhaustive BIST sequencer for a single-output combinational gate.
// Define GATE_BIST_ERRLOG_EN to add first-failing-vector capture (fail_vec/fail_valid).
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter int                      SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = TT_NAND2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
`ifdef GATE_BIST_ERRLOG_EN
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid,
`endif
    output logic [N_IN:0]   err_cnt
);

    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    bist_state_t     state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] gate_in_q, gate_in_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            gate_out_q;
    logic            mismatch;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;
`ifdef GATE_BIST_ERRLOG_EN
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;
    logic            fail_valid_q, fail_valid_d;
`endif

    bist_settle_cnt #(
        .W (CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(SETTLE - 1)),
        .zero     (cnt_zero)
    );

    // The sample compares the gate response registered on the last settle cycle.
    assign mismatch = (gate_out_q != TRUTH[idx_q]);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gate_in_d = gate_in_q;
        err_cnt_d = err_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                gate_in_d = '0;
                busy_d    = 1'b0;
                if (start) begin
                    state_d   = ST_APPLY;
                    idx_d     = '0;
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
`ifdef GATE_BIST_ERRLOG_EN
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
`endif
                end
            end
            ST_APPLY: begin
                cnt_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + (N_IN+1)'(1);
`ifdef GATE_BIST_ERRLOG_EN
                    if (!fail_valid_q) begin
                        fail_vec_d   = idx_q;
                        fail_valid_d = 1'b1;
                    end
`endif
                end
                if (idx_q == LAST_IDX) begin
                    state_d   = ST_DONE;
                    gate_in_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = (err_cnt_d == '0);
                end else begin
                    state_d   = ST_APPLY;
                    idx_d     = idx_q + N_IN'(1);
                    gate_in_d = idx_q + N_IN'(1);
                end
            end
            ST_DONE: begin
                gate_in_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                gate_in_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            gate_in_q  <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            gate_out_q <= 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gate_in_q  <= gate_in_d;
            err_cnt_q  <= err_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            gate_out_q <= gate_out;
`ifdef GATE_BIST_ERRLOG_EN
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
`endif
        end
    end

    assign gate_in = gate_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;
`ifdef GATE_BIST_ERRLOG_EN
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: default instance plus a SETTLE=3 instance
// driven by a two-cycle-delayed NAND model.
module tb_gate_bist_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] gateIn, gateIn3;
    logic       gateOut, gateOut3;
    logic       busy, done, pass;
    logic       busy3, done3, pass3;
    logic [2:0] errCnt, errCnt3;
`ifdef GATE_BIST_ERRLOG_EN
    logic [1:0] failVec, failVec3;
    logic       failValid, failValid3;
`endif

    int         mode = 0;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] ttNand = 4'b0111;
    logic [3:0] ttAnd  = 4'b1000;
    logic       dly1 = 1'b1, dly2 = 1'b1, dly1b = 1'b1, dly2b = 1'b1;

    int         firstDone, doneCount, firstDone3;
    logic       passAt, pass3At, rstZero;
    logic [2:0] errAt, err3At;
    logic [1:0] gateLog [0:40];
`ifdef GATE_BIST_ERRLOG_EN
    logic [1:0] failVecAt;
    logic       failValidAt;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dly1  <= ttNand[gateIn];
        dly2  <= dly1;
        dly1b <= ttNand[gateIn3];
        dly2b <= dly1b;
    end

    // Gate-under-test models: 0 NAND, 1 stuck-at-1, 2 AND, 3 delayed NAND.
    always_comb begin
        case (mode)
            0:       gateOut = ttNand[gateIn];
            1:       gateOut = 1'b1;
            2:       gateOut = ttAnd[gateIn];
            default: gateOut = dly2;
        endcase
    end
    assign gateOut3 = dly2b;

    gate_bist_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .gate_in    (gateIn),
        .gate_out   (gateOut),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
`ifdef GATE_BIST_ERRLOG_EN
        .fail_vec   (failVec),
        .fail_valid (failValid),
`endif
        .err_cnt    (errCnt)
    );

    gate_bist_ctrl #(.SETTLE(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .gate_in    (gateIn3),
        .gate_out   (gateOut3),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
`ifdef GATE_BIST_ERRLOG_EN
        .fail_vec   (failVec3),
        .fail_valid (failValid3),
`endif
        .err_cnt    (errCnt3)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Edge 0 is the first edge of the window; startMask bit n drives start into edge n.
    task automatic applyStimulus(input int nEdges, input logic [63:0] startMask, input int resetEdge);
        firstDone  = -1;
        firstDone3 = -1;
        doneCount  = 0;
        rstZero    = 1'b1;
        for (int n = 0; n <= nEdges; n++) begin
            @(negedge clk);
            rst_n = 1'b1;
            start = startMask[n];
            @(posedge clk);
            #1;
            if (n == resetEdge) begin
                rst_n = 1'b0;
                #1;
                rstZero = !(busy || done || pass || (errCnt != 0) || (gateIn != 0));
            end
            gateLog[n] = gateIn;
            if (done) begin
                doneCount++;
                if (firstDone < 0) begin
                    firstDone = n;
                    passAt    = pass;
                    errAt     = errCnt;
`ifdef GATE_BIST_ERRLOG_EN
                    failVecAt   = failVec;
                    failValidAt = failValid;
`endif
                end
            end
            if (done3 && (firstDone3 < 0)) begin
                firstDone3 = n;
                pass3At    = pass3;
                err3At     = errCnt3;
            end
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_err_cnt", errCnt, 0);
        checkOutput("rst_gate_in", gateIn, 0);

        mode = 0;
        applyStimulus(30, 64'h1, -1);
        checkOutput("nand_vec0", gateLog[1], 0);
        checkOutput("nand_vec1", gateLog[4], 1);
        checkOutput("nand_vec2", gateLog[7], 2);
        checkOutput("nand_vec3", gateLog[10], 3);
        checkOutput("nand_done_edge", firstDone, 12);
        checkOutput("nand_done_count", doneCount, 1);
        checkOutput("nand_pass", passAt, 1);
        checkOutput("nand_err_cnt", errAt, 0);
        checkOutput("nand_gate_in_done", gateLog[12], 0);

        mode = 1;
        applyStimulus(30, 64'h1, -1);
        checkOutput("stuck1_done_edge", firstDone, 12);
        checkOutput("stuck1_err_cnt", errAt, 1);
        checkOutput("stuck1_pass", passAt, 0);
`ifdef GATE_BIST_ERRLOG_EN
        checkOutput("stuck1_fail_vec", failVecAt, 3);
        checkOutput("stuck1_fail_valid", failValidAt, 1);
`endif

        mode = 2;
        applyStimulus(30, 64'h1, -1);
        checkOutput("and_err_cnt", errAt, 4);
        checkOutput("and_pass", passAt, 0);
`ifdef GATE_BIST_ERRLOG_EN
        checkOutput("and_fail_vec", failVecAt, 0);
        checkOutput("and_fail_valid", failValidAt, 1);
`endif

        mode = 0;
        applyStimulus(30, 64'h89, -1);
        checkOutput("repulse_done_edge", firstDone, 12);
        checkOutput("repulse_done_count", doneCount, 1);
        checkOutput("repulse_pass", passAt, 1);

        applyStimulus(30, 64'h101, 5);
        checkOutput("reset_outputs_zero", rstZero, 1);
        checkOutput("reset_done_edge", firstDone, 20);
        checkOutput("reset_done_count", doneCount, 1);
        checkOutput("reset_pass", passAt, 1);

        mode = 3;
        applyStimulus(30, 64'h1, -1);
        checkOutput("dly_s1_pass", passAt, 0);
        checkOutput("dly_s1_err_cnt", errAt, 1);
        checkOutput("dly_s3_done_edge", firstDone3, 20);
        checkOutput("dly_s3_pass", pass3At, 1);
        checkOutput("dly_s3_err_cnt", err3At, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for a single-output combinational logic gate (default: 2-input NAND). On `start` it walks every input vector, drives it onto the gate, waits a programmable settle time and samples the gate output. It compares each sample against a parameterised truth table and reports pass/fail plus a mismatch count. It sits beside the gate in the logic-cell library and replaces ad-hoc exhaustive benches with a reusable, synthesizable checker.

## Interface
- `N_IN`, default 2: number of gate inputs; the block applies 2^N_IN vectors.
- `SETTLE`, default 1: wait cycles between applying a vector and sampling; must be ≥1.
- `TRUTH`, default 4'b0111: expected output. Bit i is the response to vector i, width 2^N_IN.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: run request, sampled only in IDLE.
- `gate_in`, out, N_IN: vector driven to the gate under test. Bit N_IN-1 is the MSB, so {a,b}=i.
- `gate_out`, in, 1: gate response.
- `busy`, out, 1: high while a run is in progress.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `pass`, out, 1: high when the last completed run had zero mismatches.
- `err_cnt`, out, N_IN+1: number of mismatches in the last or current run.
- `fail_vec`, out, N_IN: first failing vector. Present only with the macro.
- `fail_valid`, out, 1: `fail_vec` holds a valid value. Present only with the macro.

## Operation
- FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE → APPLY on `start`=1. On that edge: clear `err_cnt`, vector index `idx`=0 and `pass`.
- APPLY, 1 cycle:
  - `gate_in`=`idx`.
  - Load the settle counter with SETTLE-1.
  - → WAIT.
- WAIT, SETTLE cycles: decrement the counter and hold `gate_in`; → SAMPLE when the counter is 0.
- SAMPLE, 1 cycle:
  - If `gate_out` != TRUTH[idx], increment `err_cnt`.
  - If `idx` == 2^N_IN-1, go to DONE. Otherwise increment `idx` and go to APPLY.
- DONE, 1 cycle:
  - `done`=1.
  - `pass`=(`err_cnt`==0) registered; held until the next `start`.
  - → IDLE.
- `err_cnt` cannot overflow: N_IN+1 bits cover 2^N_IN mismatches.
- `start` while not in IDLE is ignored; it is neither queued nor a restart.
- `start` held high continuously produces back-to-back runs with one IDLE cycle between them.
- `gate_in` is driven to 0 in IDLE and DONE.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `idx`=0.
- Reset mid-run: aborts immediately, with no `done` pulse; a fresh `start` runs from vector 0.
- `busy` is high in APPLY, WAIT and SAMPLE.
- Per vector: SETTLE+2 cycles.
- If `start` is accepted at edge k, `done` is high in the cycle after edge k + 2^N_IN·(SETTLE+2). For the defaults that is edge k+12.
- Sampling uses the registered `gate_out` value present during SAMPLE; the gate is assumed combinational within SETTLE cycles.

## Configuration
- `GATE_BIST_ERRLOG_EN` defined:
  - On the first mismatch of a run, capture `idx` into `fail_vec` and set `fail_valid`=1.
  - Later mismatches do not overwrite it.
  - Both fields clear on `start` and on reset.
- Not defined: `fail_vec` and `fail_valid` ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `gate_bist_pkg`:
  - FSM state enum `bist_state_t`.
  - Default truth-table constants `TT_NAND2`=4'b0111, `TT_AND2`=4'b1000, `TT_NOR2`=4'b0001.
- One natural sub-module, `bist_settle_cnt`: a loadable down-counter with a zero flag, sized $clog2(SETTLE+1).

## Test plan
- Correct NAND model, defaults, `start` pulse at edge 0:
  - vectors 0,1,2,3 applied in order;
  - `done` at edge 12;
  - `pass`=1, `err_cnt`=0.
- Output stuck-at-1: `err_cnt`=1, `pass`=0, `fail_vec`=3, `fail_valid`=1.
- AND model substituted: `err_cnt`=4, `pass`=0, `fail_vec`=0.
- `start` re-pulsed at edges 3 and 7 during a run: ignored, `done` still at edge 12 only, single run.
- `rst_n` asserted at edge 5:
  - all outputs 0 immediately, no `done`;
  - a `start` at edge 8 completes with `done` at edge 20 and `pass`=1.
- SETTLE=3 with a gate model delayed by 2 cycles: `pass`=1, `done` at edge 20. With SETTLE=1 the same model gives `pass`=0.
